// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: iterative AES-128 inverse cipher controller.
// One ciphertext block moves through one shared round datapath, one round
// per clock. Round keys are read combinationally from an external store
// that this block addresses through rk_addr_o.
module aes_dec_round_ctrl #(
  parameter int NR = 10
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [127:0]               data_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [127:0]               data_o,
  input  logic                       ready_i,
  output logic [$clog2(NR+1)-1:0]    rk_addr_o,
  input  logic [127:0]               rk_data_i,
  output logic                       busy_o
);

  localparam int RW = $clog2(NR+1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t         state, state_nxt;
  logic [127:0]   st, st_nxt;
  logic [RW-1:0]  rnd, rnd_nxt;
  logic           valid_q;

  logic [127:0]   sub_out;
  logic [127:0]   ark_out;
  logic [127:0]   imc_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, x);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, x);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, x);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, x);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, x);
    return gmul(x127, x127);
  endfunction

  // Inverse S-box: undo the affine transform, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  // Byte k = row + 4*col sits at [127-8k -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 4; k++) begin
      o[127-32*k -: 32] = inv_mix_col(s[127-32*k -: 32]);
    end
    return o;
  endfunction

  // Single shared round datapath; FINAL simply takes the tap before InvMixColumns.
  assign sub_out = inv_sub_bytes(inv_shift_rows(st));
  assign ark_out = sub_out ^ rk_data_i;
  assign imc_out = inv_mix_columns(ark_out);

  // Next-state, key addressing and handshake decode; ready_o depends on state only.
  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    rnd_nxt   = rnd;
    rk_addr_o = '0;
    ready_o   = 1'b0;
    busy_o    = 1'b0;
    case (state)
      IDLE: begin
        ready_o   = 1'b1;
        rk_addr_o = RW'(NR);
        if (valid_i) begin
          st_nxt    = data_i ^ rk_data_i;
          rnd_nxt   = RW'(NR - 1);
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        busy_o    = 1'b1;
        rk_addr_o = rnd;
        st_nxt    = imc_out;
        rnd_nxt   = rnd - RW'(1);
        if (rnd == RW'(1)) state_nxt = FINAL;
      end
      FINAL: begin
        busy_o    = 1'b1;
        st_nxt    = ark_out;
        state_nxt = DONE;
      end
      DONE: begin
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round counter and registered output-valid; reset discards any block in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      st      <= '0;
      rnd     <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      st      <= st_nxt;
      rnd     <= rnd_nxt;
      valid_q <= (state_nxt == DONE);
    end
  end

  assign valid_o = valid_q;
  assign data_o  = valid_q ? st : '0;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb_aes_dec_round_ctrl: table-driven and randomized checks of the AES-128
// decryption round controller against a byte-matrix inverse-cipher model.
module tb_aes_dec_round_ctrl;

  typedef logic [10:0][127:0] sched_t;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    logic [127:0] pt;
    int           stall;
  } vec_t;

  localparam int NRND     = 10;
  localparam int LATENCY  = NRND;
  localparam int INTERVAL = LATENCY + 2;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         valid_i;
  logic [127:0] data_i;
  logic         ready_o;
  logic         valid_o;
  logic [127:0] data_o;
  logic         ready_i;
  logic [3:0]   rk_addr_o;
  logic [127:0] rk_data_i;
  logic         busy_o;

  logic [127:0] rk_mem [0:15];
  logic [7:0]   sbox  [0:255];
  logic [7:0]   isbox [0:255];

  int checks   = 0;
  int failures = 0;

  aes_dec_round_ctrl #(.NR(NRND)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .ready_i   (ready_i),
    .rk_addr_o (rk_addr_o),
    .rk_data_i (rk_data_i),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  assign rk_data_i = rk_mem[rk_addr_o];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r[(i + n) % 8] = x[i];
    return r;
  endfunction

  // Forward S-box from first principles (brute-force inverse + affine), then invert the table.
  task automatic buildSboxes();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic sched_t expandKey(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    sched_t      out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) out[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return out;
  endfunction

  // Textbook inverse cipher on a 4x4 byte matrix s[row][col].
  function automatic logic [127:0] modelDecrypt(input logic [127:0] ct, input sched_t rk);
    logic [7:0]   s [0:3][0:3];
    logic [7:0]   t [0:3][0:3];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k;
    logic [127:0] res;
    k = rk[10];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = ct[127-8*(r+4*c) -: 8] ^ k[127-8*(r+4*c) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      t = s;
      k = rk[rnd];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = isbox[t[r][(c - r + 4) % 4]] ^ k[127-8*(r+4*c) -: 8];
      if (rnd != 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
          s[1][c] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
          s[2][c] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
          s[3][c] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
        end
      end
    end
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic sched_t currentSched();
    sched_t s;
    for (int r = 0; r <= 10; r++) s[r] = rk_mem[r];
    return s;
  endfunction

  task automatic loadKey(input logic [127:0] key);
    sched_t s;
    s = expandKey(key);
    for (int r = 0; r < 16; r++) rk_mem[r] = (r <= 10) ? s[r] : '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] ct);
    valid_i = 1'b1;
    data_i  = ct;
  endtask

  // One full block: accept, watch every round cycle, optional stall, handshake.
  task automatic runBlock(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                          input int stall, input bit poke, input logic [127:0] pokeCt);
    int guard;
    guard = 0;
    while (!ready_o && guard < 40) begin
      step();
      guard++;
    end
    checkOutput({tag, " ready_before_accept"}, 128'(ready_o), 128'(1));
    checkOutput({tag, " rk_addr_idle"}, 128'(rk_addr_o), 128'(NRND));
    applyStimulus(ct);
    step();
    valid_i = 1'b0;
    for (int i = 1; i <= LATENCY; i++) begin
      checkOutput($sformatf("%s rk_addr_c%0d", tag, i), 128'(rk_addr_o), 128'(NRND - i));
      checkOutput($sformatf("%s busy_c%0d", tag, i), 128'(busy_o), 128'(1));
      checkOutput($sformatf("%s ready_c%0d", tag, i), 128'(ready_o), 128'(0));
      checkOutput($sformatf("%s valid_c%0d", tag, i), 128'(valid_o), 128'(0));
      if (poke && i == 3) begin
        valid_i = 1'b1;
        data_i  = pokeCt;
      end
      step();
    end
    checkOutput({tag, " valid_at_latency"}, 128'(valid_o), 128'(1));
    checkOutput({tag, " busy_done"}, 128'(busy_o), 128'(0));
    checkOutput({tag, " ready_done"}, 128'(ready_o), 128'(0));
    checkOutput({tag, " data"}, data_o, exp);
    for (int k = 0; k < stall; k++) begin
      step();
      checkOutput($sformatf("%s stall%0d valid", tag, k), 128'(valid_o), 128'(1));
      checkOutput($sformatf("%s stall%0d data", tag, k), data_o, exp);
      checkOutput($sformatf("%s stall%0d ready", tag, k), 128'(ready_o), 128'(0));
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checkOutput({tag, " ready_after_hs"}, 128'(ready_o), 128'(1));
    checkOutput({tag, " valid_after_hs"}, 128'(valid_o), 128'(0));
    checkOutput({tag, " busy_after_hs"}, 128'(busy_o), 128'(0));
  endtask

  initial begin
    vec_t         vecs [0:5];
    int           acc [$];
    logic [127:0] outs [$];
    int           cyc;
    int           stray;
    int           bitPos;
    logic [127:0] base;
    logic [127:0] key2;
    logic [127:0] ct2;

    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;

    buildSboxes();

    vecs[0] = '{C1_CT, C1_KEY, C1_PT, 0};
    vecs[1] = '{B_CT, B_KEY, B_PT, 2};
    for (int i = 2; i < 6; i++) begin
      vecs[i].key   = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].ct    = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt    = modelDecrypt(vecs[i].ct, expandKey(vecs[i].key));
      vecs[i].stall = int'($urandom_range(0, 3));
    end

    @(negedge clk);
    step();
    step();
    reset_i = 1'b0;
    checkOutput("reset ready", 128'(ready_o), 128'(1));
    checkOutput("reset valid", 128'(valid_o), 128'(0));
    checkOutput("reset busy", 128'(busy_o), 128'(0));
    checkOutput("reset data", data_o, '0);
    checkOutput("reset rk_addr", 128'(rk_addr_o), 128'(NRND));

    for (int i = 0; i < 6; i++) begin
      loadKey(vecs[i].key);
      runBlock($sformatf("vec%0d", i), vecs[i].ct, vecs[i].pt, vecs[i].stall, 1'b0, '0);
    end

    loadKey(C1_KEY);
    runBlock("backpressure", C1_CT, C1_PT, 5, 1'b0, '0);

    key2 = {$urandom, $urandom, $urandom, $urandom};
    ct2  = {$urandom, $urandom, $urandom, $urandom};
    loadKey(key2);
    runBlock("busy_first", C1_CT, modelDecrypt(C1_CT, expandKey(key2)), 1, 1'b1, ct2);
    runBlock("busy_second", ct2, modelDecrypt(ct2, expandKey(key2)), 0, 1'b0, '0);

    loadKey(C1_KEY);
    applyStimulus(C1_CT);
    step();
    valid_i = 1'b0;
    for (int i = 1; i < 5; i++) step();
    checkOutput("midreset rk_addr_before", 128'(rk_addr_o), 128'(5));
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    checkOutput("midreset valid", 128'(valid_o), 128'(0));
    checkOutput("midreset busy", 128'(busy_o), 128'(0));
    checkOutput("midreset ready", 128'(ready_o), 128'(1));
    checkOutput("midreset data", data_o, '0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_o) stray++;
      step();
    end
    checkOutput("midreset no_stray_valid", 128'(stray), 128'(0));
    runBlock("after_reset", C1_CT, C1_PT, 0, 1'b0, '0);

    loadKey(C1_KEY);
    ready_i = 1'b1;
    applyStimulus(C1_CT);
    cyc = 0;
    while (outs.size() < 2 && cyc < 60) begin
      if (ready_o && valid_i) acc.push_back(cyc);
      if (valid_o) outs.push_back(data_o);
      step();
      cyc++;
      if (acc.size() >= 2) valid_i = 1'b0;
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    checkOutput("b2b outputs_seen", 128'(outs.size()), 128'(2));
    checkOutput("b2b accepts_seen", 128'(acc.size()), 128'(2));
    if (acc.size() >= 2)
      checkOutput("b2b accept_interval", 128'(acc[1] - acc[0]), 128'(INTERVAL));
    if (outs.size() >= 2) begin
      checkOutput("b2b data0", outs[0], C1_PT);
      checkOutput("b2b data1", outs[1], C1_PT);
    end
    step();

    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    base = modelDecrypt('0, currentSched());
    runBlock("zero_sched", '0, base, 0, 1'b0, '0);
    bitPos = int'($urandom_range(0, 127));
    rk_mem[0][bitPos] = ~rk_mem[0][bitPos];
    runBlock("rk0_bitflip", '0, base ^ (128'd1 << bitPos), 0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
